fsm_sequencer: RTL and testbench
================================

Name: fsm_sequencer

Overview:
Initiator-side controller for the `fsm` worker, which consumes a `start`/`done` pulse pair and reports an 8-bit `state`. It replaces hand-written bench stimulus with synthesizable logic. On a `go` request it issues a programmed number of jobs to the worker, one at a time: a one-cycle `start`, then a wait for `done`. It enforces worker-idle checks and timeouts, and reports progress and errors to the surrounding control logic.

Parameters:
- CNT_W, 8, width of the job count and completed-job counter.
- TIMEOUT, 16, maximum cycles spent in CHECK or WAIT before error; legal range 2..255.

Ports:
- clock, input, 1, sole clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-low reset.
- go, input, 1, batch request; sampled only in IDLE.
- num_jobs, input, CNT_W, number of jobs in the batch; latched when go is accepted.
- clear, input, 1, leaves ERROR and returns to IDLE.
- worker_state, input, 8, worker `state` output; 0 means idle.
- done, input, 1, worker completion pulse.
- start, output, 1, one-cycle job start pulse to the worker.
- busy, output, 1, high in CHECK, ISSUE, WAIT and FINISH.
- finished, output, 1, one-cycle pulse when the batch completes.
- timeout_err, output, 1, sticky error flag; high only in ERROR.
- spurious_done, output, 1, sticky flag set by a done seen outside WAIT; cleared on go acceptance or clear.
- jobs_done, output, CNT_W, completed jobs in the current or last batch.

Behaviour:
- Reset (reset == 0, asynchronous):
  - FSM goes to IDLE.
  - start, busy, finished, timeout_err and spurious_done are 0.
  - jobs_done, the latched target and the timer are 0.
  - Reset asserted mid-batch aborts immediately; start drops without completing its pulse.
- Outputs are registered and decoded from the state register: start = ISSUE, finished = FINISH, timeout_err = ERROR.
- States and transitions (evaluated at each posedge):
  - IDLE:
    - go=1, num_jobs≠0: latch target=num_jobs, jobs_done←0, spurious_done←0, timer←0, go to CHECK.
    - go=1, num_jobs=0: latch the same way, then go to FINISH; no start is issued.
    - go=0: stay.
  - CHECK:
    - worker_state==0: go to ISSUE.
    - Otherwise, timer==TIMEOUT-1: go to ERROR.
    - Otherwise: timer++.
  - ISSUE: start=1 for exactly this cycle; timer←0; go to WAIT unconditionally.
  - WAIT:
    - done=1: jobs_done++, timer←0; go to FINISH if the new jobs_done==target, else CHECK.
    - Otherwise, timer==TIMEOUT-1: go to ERROR.
    - Otherwise: timer++.
  - FINISH: finished=1 for one cycle; go to IDLE.
  - ERROR: hold; clear=1 goes to IDLE. jobs_done is frozen in ERROR.
- Latency:
  - go accepted at edge k → CHECK.
  - With worker idle, start is high in the cycle between edges k+1 and k+2.
  - Earliest done is sampled at edge k+3.
  - finished is high in the cycle after the final done.
- Boundary rules:
  - go while busy or in ERROR: ignored.
  - done outside WAIT (including in the ISSUE cycle): not counted; sets spurious_done.
  - done and timeout on the same edge: done wins.
  - clear outside ERROR: no effect.
  - clear and go together in ERROR: only clear acts; go is ignored.
  - jobs_done never exceeds target. A target of 2^CNT_W-1 is legal; there is no wrap.
  - num_jobs changing after acceptance has no effect.
- Each timeout allows exactly TIMEOUT sampled cycles in CHECK or WAIT.

Test Plan:
- Single job with the real `fsm` worker: go=1, num_jobs=1 → start pulse of one cycle, done returns, finished pulses once, jobs_done=1, busy=0 afterwards, worker_state back to 0.
- Batch of 3 with a worker model that answers done 2 cycles after start → exactly 3 start pulses, each preceded by worker_state==0, then finished, jobs_done=3, no spurious_done.
- num_jobs=0 → no start, finished high the cycle after go acceptance, jobs_done=0.
- Worker never asserts done, TIMEOUT=16 → ERROR after exactly 16 WAIT cycles, timeout_err=1, jobs_done frozen. clear=1 → IDLE, timeout_err=0. A go in the same cycle as clear is ignored.
- worker_state held at 5 → stuck in CHECK, no start, ERROR after 16 cycles. Separately, done injected in the ISSUE cycle → spurious_done=1 and not counted.
- Reset (reset=0) asserted while in WAIT during job 2 of 4 → all outputs 0 without waiting for a clock edge. After release, a new go with num_jobs=1 runs cleanly.

Source files
------------

// File: rtl/fsm_sequencer.sv
// fsm_sequencer: drives the fsm worker through a programmed batch of jobs.
// Each job is a single-cycle start pulse followed by a wait for done. The
// worker must be idle before each start is issued. Timeouts and stray done
// pulses are reported to the surrounding control logic.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for go; the last batch's jobs_done stays visible
// CHECK  | waiting for worker_state == 0 before the next job
// ISSUE  | start pulse for one cycle
// WAIT   | waiting for done from the worker
// FINISH | finished pulse for one cycle
// ERROR  | timed out in CHECK or WAIT; held until clear
module fsm_sequencer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [CNT_W-1:0] num_jobs,
  input  logic             clear,
  input  logic [7:0]       worker_state,
  input  logic             done,
  output logic             start,
  output logic             busy,
  output logic             finished,
  output logic             timeout_err,
  output logic             spurious_done,
  output logic [CNT_W-1:0] jobs_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // The timer counts down from TIMEOUT-1 and expires when it reads zero.
  // This gives exactly TIMEOUT sampled cycles in CHECK or WAIT.
  localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] target, target_nx;
  logic [CNT_W-1:0] jobs_nx, jobs_inc;
  logic [7:0]       timer, timer_nx;
  logic             spur_nx;

  assign jobs_inc = jobs_done + {{(CNT_W-1){1'b0}}, 1'b1};

  // State, batch bookkeeping and timer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      target        <= '0;
      jobs_done     <= '0;
      timer         <= '0;
      spurious_done <= 1'b0;
    end else begin
      state         <= state_nx;
      target        <= target_nx;
      jobs_done     <= jobs_nx;
      timer         <= timer_nx;
      spurious_done <= spur_nx;
    end
  end

  // Next-state logic. A done outside WAIT is never counted. It only sets the
  // sticky flag, and go acceptance or clear drops that flag.
  always_comb begin
    state_nx  = state;
    target_nx = target;
    jobs_nx   = jobs_done;
    timer_nx  = timer;
    spur_nx   = spurious_done | (done && (state != WAIT));
    case (state)
      IDLE: begin
        if (go) begin
          target_nx = num_jobs;
          jobs_nx   = '0;
          spur_nx   = 1'b0;
          timer_nx  = TIMER_LOAD;
          state_nx  = (num_jobs == '0) ? FINISH : CHECK;
        end
      end
      CHECK: begin
        if (worker_state == 8'd0) begin
          state_nx = ISSUE;
        end else if (timer == 8'd0) begin
          state_nx = ERROR;
        end else begin
          timer_nx = timer - 8'd1;
        end
      end
      ISSUE: begin
        timer_nx = TIMER_LOAD;
        state_nx = WAIT;
      end
      WAIT: begin
        // done takes priority over a timeout on the same edge
        if (done) begin
          jobs_nx  = jobs_inc;
          timer_nx = TIMER_LOAD;
          state_nx = (jobs_inc == target) ? FINISH : CHECK;
        end else if (timer == 8'd0) begin
          state_nx = ERROR;
        end else begin
          timer_nx = timer - 8'd1;
        end
      end
      FINISH: begin
        state_nx = IDLE;
      end
      ERROR: begin
        if (clear) begin
          spur_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign start       = (state == ISSUE);
  assign finished    = (state == FINISH);
  assign timeout_err = (state == ERROR);
  assign busy        = (state == CHECK) || (state == ISSUE) ||
                       (state == WAIT)  || (state == FINISH);

endmodule

// File: tb/tb_fsm_sequencer.sv
// Bench for fsm_sequencer. A behavioural worker answers each start after a
// programmable latency. Expected start and finish cycles come from the batch
// timing rule: with the go accepted at edge k, job j starts at edge
// k+1+j*(L+2), and finished follows at edge k+n*(L+2).
module tb_fsm_sequencer;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             go = 1'b0;
  logic             clear = 1'b0;
  logic             done = 1'b0;
  logic [CNT_W-1:0] num_jobs = '0;
  logic [7:0]       worker_state = 8'd0;
  logic             start, busy, finished, timeout_err, spurious_done;
  logic [CNT_W-1:0] jobs_done;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  int         start_q[$];
  int         fin_q[$];
  int         ws_bad = 0;
  logic [7:0] ws_prev = 8'd0;

  int         wl = 2;
  int         wk_answers = 1000000;
  int         served = 0;
  int         wcnt = 0;
  bit         inject = 1'b0;
  bit         wk_reset = 1'b0;
  logic [7:0] force_ws = 8'd0;

  fsm_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .go            (go),
    .num_jobs      (num_jobs),
    .clear         (clear),
    .worker_state  (worker_state),
    .done          (done),
    .start         (start),
    .busy          (busy),
    .finished      (finished),
    .timeout_err   (timeout_err),
    .spurious_done (spurious_done),
    .jobs_done     (jobs_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Monitor: logs the start and finished cycles, and checks that the worker was idle when each start was decided.
  always @(negedge clock) begin
    if (start) begin
      start_q.push_back(cyc);
      if (ws_prev != 8'd0) ws_bad++;
    end
    if (finished) fin_q.push_back(cyc);
    ws_prev = worker_state;
  end

  // Worker model: goes busy on start, then pulses done after wl cycles.
  // It serves the first wk_answers jobs of a batch. After that it stays busy and never answers.
  always @(posedge clock) begin
    #2;
    done = 1'b0;
    if (!reset || wk_reset) begin
      wcnt = 0;
      worker_state = force_ws;
    end else if (start) begin
      if (inject) done = 1'b1;
      worker_state = 8'h03;
      wcnt = (served < wk_answers) ? wl : 0;
    end else if (wcnt > 0) begin
      wcnt--;
      if (wcnt == 0) begin
        done = 1'b1;
        worker_state = 8'd0;
        served++;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic launch(input int n, output int k);
    start_q.delete();
    fin_q.delete();
    ws_bad = 0;
    served = 0;
    tick();
    go = 1'b1;
    num_jobs = CNT_W'(n);
    tick();
    k = cyc;
    go = 1'b0;
    num_jobs = CNT_W'($urandom);
  endtask

  task automatic wait_fin(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (fin_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic worker_flush();
    wk_reset = 1'b1;
    tick();
    tick();
    wk_reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({start, busy, finished, timeout_err, spurious_done} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000",
               {start, busy, finished, timeout_err, spurious_done});
    else passed++;
    checks++;
    if (jobs_done !== '0) $display("FAIL reset_jobs_done: got %0d expected 0", jobs_done);
    else passed++;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int k;
    bit ok;
    int s0, f0;
    wl = 2;
    launch(1, k);
    wait_fin(40, ok);
    checks++;
    if (!ok) $display("FAIL single_finish_timeout: got none expected finished");
    else passed++;
    s0 = (start_q.size() > 0) ? start_q[0] : -1;
    f0 = (fin_q.size() > 0) ? fin_q[0] : -1;
    checks++;
    if (start_q.size() != 1) $display("FAIL single_start_count: got %0d expected 1", start_q.size());
    else passed++;
    checks++;
    if (s0 != k + 1) $display("FAIL single_start_cycle: got %0d expected %0d", s0, k + 1);
    else passed++;
    checks++;
    if (f0 != k + 4) $display("FAIL single_finish_cycle: got %0d expected %0d", f0, k + 4);
    else passed++;
    tick();
    checks++;
    if ({finished, busy} !== 2'b00) $display("FAIL single_after: got fin/busy %b expected 00", {finished, busy});
    else passed++;
    checks++;
    if (jobs_done !== 8'd1 || worker_state !== 8'd0 || spurious_done !== 1'b0)
      $display("FAIL single_final: got jobs %0d ws %0d spur %b expected 1 0 0",
               jobs_done, worker_state, spurious_done);
    else passed++;
  endtask

  task automatic test_batches();
    for (int it = 0; it < 6; it++) begin
      int n, lat, k, bad, f0;
      bit ok;
      n = (it == 0) ? 3 : int'($urandom_range(1, 6));
      lat = (it == 0) ? 2 : int'($urandom_range(1, 5));
      wl = lat;
      launch(n, k);
      wait_fin(n * (lat + 2) + 20, ok);
      bad = 0;
      if (start_q.size() != n) bad++;
      else foreach (start_q[j]) if (start_q[j] != k + 1 + j * (lat + 2)) bad++;
      f0 = (fin_q.size() > 0) ? fin_q[0] : -1;
      checks++;
      if (!ok || bad != 0)
        $display("FAIL batch_starts n=%0d L=%0d: got %0d starts (%0d off-schedule) expected %0d",
                 n, lat, start_q.size(), bad, n);
      else passed++;
      checks++;
      if (f0 != k + n * (lat + 2))
        $display("FAIL batch_finish n=%0d L=%0d: got %0d expected %0d", n, lat, f0, k + n * (lat + 2));
      else passed++;
      checks++;
      if (jobs_done !== CNT_W'(n) || ws_bad != 0 || spurious_done !== 1'b0)
        $display("FAIL batch_result n=%0d: got jobs %0d wsbad %0d spur %b expected %0d 0 0",
                 n, jobs_done, ws_bad, spurious_done, n);
      else passed++;
      tick();
      checks++;
      if (fin_q.size() != 1 || busy !== 1'b0)
        $display("FAIL batch_single_finish: got %0d finishes busy %b expected 1 0", fin_q.size(), busy);
      else passed++;
    end
  endtask

  task automatic test_zero();
    int k;
    int f0;
    launch(0, k);
    f0 = (fin_q.size() > 0) ? fin_q[0] : -1;
    checks++;
    if (f0 != k) $display("FAIL zero_finish_cycle: got %0d expected %0d", f0, k);
    else passed++;
    repeat (4) tick();
    checks++;
    if (start_q.size() != 0 || jobs_done !== '0 || fin_q.size() != 1)
      $display("FAIL zero_result: got starts %0d jobs %0d fins %0d expected 0 0 1",
               start_q.size(), jobs_done, fin_q.size());
    else passed++;
  endtask

  task automatic test_max();
    int k;
    bit ok;
    int f0;
    wl = 1;
    launch(255, k);
    wait_fin(255 * 3 + 20, ok);
    f0 = (fin_q.size() > 0) ? fin_q[0] : -1;
    checks++;
    if (f0 != k + 255 * 3) $display("FAIL max_finish: got %0d expected %0d", f0, k + 255 * 3);
    else passed++;
    repeat (3) tick();
    checks++;
    if (jobs_done !== 8'd255 || start_q.size() != 255)
      $display("FAIL max_result: got jobs %0d starts %0d expected 255 255", jobs_done, start_q.size());
    else passed++;
  endtask

  task automatic test_timeout_wait();
    int k;
    wl = 2;
    wk_answers = 1;
    launch(3, k);
    wait_cyc(k + 21);
    checks++;
    if ({timeout_err, busy} !== 2'b01) $display("FAIL wait_pre_timeout: got err/busy %b expected 01", {timeout_err, busy});
    else passed++;
    tick();
    checks++;
    if ({timeout_err, busy} !== 2'b10 || jobs_done !== 8'd1)
      $display("FAIL wait_timeout: got err/busy %b jobs %0d expected 10 1", {timeout_err, busy}, jobs_done);
    else passed++;
    go = 1'b1;
    num_jobs = 8'd2;
    tick();
    go = 1'b0;
    repeat (3) tick();
    checks++;
    if (timeout_err !== 1'b1 || jobs_done !== 8'd1 || start_q.size() != 2)
      $display("FAIL error_hold: got err %b jobs %0d starts %0d expected 1 1 2",
               timeout_err, jobs_done, start_q.size());
    else passed++;
    go = 1'b1;
    clear = 1'b1;
    num_jobs = 8'd2;
    tick();
    go = 1'b0;
    clear = 1'b0;
    checks++;
    if ({timeout_err, busy} !== 2'b00) $display("FAIL clear_exit: got err/busy %b expected 00", {timeout_err, busy});
    else passed++;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || start_q.size() != 2)
      $display("FAIL clear_go_ignored: got busy %b starts %0d expected 0 2", busy, start_q.size());
    else passed++;
    wk_answers = 1000000;
    worker_flush();
  endtask

  task automatic test_timeout_boundary();
    int k;
    bit ok;
    int f0;
    wl = 16;
    clear = 1'b1;
    launch(1, k);
    wait_fin(40, ok);
    f0 = (fin_q.size() > 0) ? fin_q[0] : -1;
    checks++;
    if (f0 != k + 18 || timeout_err !== 1'b0 || jobs_done !== 8'd1)
      $display("FAIL done_beats_timeout: got fin %0d err %b jobs %0d expected %0d 0 1",
               f0, timeout_err, jobs_done, k + 18);
    else passed++;
    clear = 1'b0;
    wl = 17;
    launch(1, k);
    wait_cyc(k + 17);
    checks++;
    if (timeout_err !== 1'b0) $display("FAIL late_pre_timeout: got %b expected 0", timeout_err);
    else passed++;
    tick();
    checks++;
    if (timeout_err !== 1'b1 || jobs_done !== '0 || fin_q.size() != 0)
      $display("FAIL late_timeout: got err %b jobs %0d fins %0d expected 1 0 0",
               timeout_err, jobs_done, fin_q.size());
    else passed++;
    tick();
    checks++;
    if (spurious_done !== 1'b1) $display("FAIL done_in_error: got spur %b expected 1", spurious_done);
    else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({timeout_err, spurious_done} !== 2'b00)
      $display("FAIL clear_flags: got err/spur %b expected 00", {timeout_err, spurious_done});
    else passed++;
    worker_flush();
  endtask

  task automatic test_check_timeout();
    int k;
    force_ws = 8'd5;
    worker_flush();
    launch(2, k);
    wait_cyc(k + 15);
    checks++;
    if ({timeout_err, busy} !== 2'b01) $display("FAIL check_pre_timeout: got err/busy %b expected 01", {timeout_err, busy});
    else passed++;
    tick();
    checks++;
    if (timeout_err !== 1'b1 || start_q.size() != 0)
      $display("FAIL check_timeout: got err %b starts %0d expected 1 0", timeout_err, start_q.size());
    else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    force_ws = 8'd0;
    worker_flush();
  endtask

  task automatic test_spurious();
    int k;
    bit ok;
    int f0;
    wl = 3;
    inject = 1'b1;
    launch(1, k);
    wait_fin(30, ok);
    inject = 1'b0;
    f0 = (fin_q.size() > 0) ? fin_q[0] : -1;
    checks++;
    if (f0 != k + 5 || jobs_done !== 8'd1 || start_q.size() != 1)
      $display("FAIL issue_done_counted: got fin %0d jobs %0d starts %0d expected %0d 1 1",
               f0, jobs_done, start_q.size(), k + 5);
    else passed++;
    checks++;
    if (spurious_done !== 1'b1) $display("FAIL issue_done_flag: got %b expected 1", spurious_done);
    else passed++;
    wl = 2;
    launch(1, k);
    checks++;
    if (spurious_done !== 1'b0) $display("FAIL spur_cleared_on_go: got %b expected 0", spurious_done);
    else passed++;
    wait_fin(30, ok);
    checks++;
    if (!ok || spurious_done !== 1'b0 || jobs_done !== 8'd1)
      $display("FAIL clean_after_spur: got ok %b spur %b jobs %0d expected 1 0 1", ok, spurious_done, jobs_done);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int k;
    bit ok;
    int f0;
    wl = 6;
    launch(4, k);
    wait_cyc(k + 12);
    checks++;
    if (busy !== 1'b1 || jobs_done !== 8'd1)
      $display("FAIL mid_pre_reset: got busy %b jobs %0d expected 1 1", busy, jobs_done);
    else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({start, busy, finished, timeout_err, spurious_done} !== 5'b0 || jobs_done !== '0)
      $display("FAIL mid_reset_async: got flags %b jobs %0d expected 00000 0",
               {start, busy, finished, timeout_err, spurious_done}, jobs_done);
    else passed++;
    tick();
    reset = 1'b1;
    tick();
    wl = 2;
    launch(1, k);
    wait_fin(30, ok);
    f0 = (fin_q.size() > 0) ? fin_q[0] : -1;
    checks++;
    if (f0 != k + 4 || jobs_done !== 8'd1 || start_q.size() != 1)
      $display("FAIL post_reset_run: got fin %0d jobs %0d starts %0d expected %0d 1 1",
               f0, jobs_done, start_q.size(), k + 4);
    else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_batches();
    test_zero();
    test_max();
    test_timeout_wait();
    test_timeout_boundary();
    test_check_timeout();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
